// File: rtl/key_led_mode_ctrl_pkg.sv
// Shared mode encodings, LED pattern constants and pattern helpers for the
// key-driven LED mode controller.
package key_led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SHR   = 2'd0,
    MODE_SHL   = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  localparam logic [3:0] PAT_ONE  = 4'b0001;
  localparam logic [3:0] PAT_ALL  = 4'b1111;
  localparam logic [3:0] PAT_NONE = 4'b0000;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_SHR:   next_mode = MODE_SHL;
      MODE_SHL:   next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_OFF;
      default:    next_mode = MODE_SHR;
    endcase
  endfunction

  // Pattern loaded when a mode is entered.
  function automatic logic [3:0] entry_pattern(input mode_e m);
    case (m)
      MODE_SHR, MODE_SHL: entry_pattern = PAT_ONE;
      MODE_BLINK:         entry_pattern = PAT_ALL;
      default:            entry_pattern = PAT_NONE;
    endcase
  endfunction

  // One animation step at the tick terminal count.
  function automatic logic [3:0] step_pattern(input mode_e m, input logic [3:0] l);
    case (m)
      MODE_SHR:   step_pattern = {l[0], l[3:1]};
      MODE_SHL:   step_pattern = {l[2:0], l[3]};
      MODE_BLINK: step_pattern = ~l;
      default:    step_pattern = l;
    endcase
  endfunction

endpackage

// File: rtl/key_led_mode_ctrl_classifier.sv
// Classifies debounced key presses as short or long and emits a one-cycle
// pulse for each classified press.
module key_press_classifier #(
  parameter int LONG_MAX = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_value,
  output logic press_short,
  output logic press_long
);

  localparam int HW = (LONG_MAX > 1) ? $clog2(LONG_MAX) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'(LONG_MAX - 1);

  logic          pressed_r;
  logic [HW-1:0] hold_cnt;
  logic          long_fired;

  logic press_ev, release_ev, long_ev;

  // Strobes at the level already held are ignored.
  assign press_ev   = key_flag & ~key_value & ~pressed_r;
  assign release_ev = key_flag &  key_value &  pressed_r;
  assign long_ev    = pressed_r & ~release_ev & ~long_fired & (hold_cnt == HOLD_TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed_r   <= 1'b0;
      hold_cnt    <= '0;
      long_fired  <= 1'b0;
      press_short <= 1'b0;
      press_long  <= 1'b0;
    end else begin
      press_short <= 1'b0;
      press_long  <= 1'b0;
      if (press_ev) begin
        pressed_r  <= 1'b1;
        hold_cnt   <= '0;
        long_fired <= 1'b0;
      end else if (release_ev) begin
        pressed_r   <= 1'b0;
        press_short <= ~long_fired;
      end else if (pressed_r) begin
        if (hold_cnt != HOLD_TOP) hold_cnt <= hold_cnt + 1'b1;
        if (long_ev) begin
          press_long <= 1'b1;
          long_fired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_led_mode_ctrl.sv
// LED pattern engine: short press cycles the display mode, long press toggles
// pause; the pattern advances once every TICK_MAX clocks while running.
module key_led_mode_ctrl
  import key_led_mode_ctrl_pkg::*;
#(
  parameter int TICK_MAX = 25_000_000,
  parameter int LONG_MAX = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_flag,
  input  logic       key_value,
  output logic [3:0] led_out,
  output logic [1:0] mode,
  output logic       paused,
  output logic       press_short,
  output logic       press_long
);

  localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TW-1:0] TICK_TOP = TW'(TICK_MAX - 1);

  mode_e         mode_q, mode_d;
  logic [TW-1:0] tick_cnt;
  logic          tick_end;

  key_press_classifier #(.LONG_MAX(LONG_MAX)) u_classifier (
    .clk         (clk),
    .rst         (rst),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .press_short (press_short),
    .press_long  (press_long)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= MODE_SHR;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (press_short) mode_d = next_mode(mode_q);
  end

  assign mode     = mode_q;
  assign tick_end = (tick_cnt == TICK_TOP);

  // A mode reload beats a coincident step; the pause toggle lands a cycle
  // after any step evaluated with the old paused value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paused   <= 1'b0;
      tick_cnt <= '0;
      led_out  <= PAT_ONE;
    end else begin
      if (press_long) paused <= ~paused;
      if (press_short) begin
        led_out  <= entry_pattern(mode_d);
        tick_cnt <= '0;
      end else if (!paused) begin
        if (tick_end) begin
          tick_cnt <= '0;
          led_out  <= step_pattern(mode_q, led_out);
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// Directed and randomized bench for key_led_mode_ctrl against a cycle-level
// reference model built from press age and arithmetic LED patterns.
module tb_key_led_mode_ctrl;

  localparam int TICK_MAX = 4;
  localparam int LONG_MAX = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_flag = 1'b0;
  logic       key_value = 1'b1;
  logic [3:0] led_out;
  logic [1:0] mode;
  logic       paused;
  logic       press_short;
  logic       press_long;

  int checks = 0;
  int errors = 0;

  key_led_mode_ctrl #(.TICK_MAX(TICK_MAX), .LONG_MAX(LONG_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .led_out     (led_out),
    .mode        (mode),
    .paused      (paused),
    .press_short (press_short),
    .press_long  (press_long)
  );

  always #5 clk = ~clk;

  // Reference model: press age counts edges since the press strobe.
  bit m_held;
  int m_age;
  bit m_ps, m_pl;
  int m_mode;
  bit m_paused;
  int m_tick;
  int m_led;

  function automatic int entry_led(input int md);
    if (md <= 1) return 1;
    if (md == 2) return 15;
    return 0;
  endfunction

  function automatic int step_led(input int md, input int l);
    case (md)
      0: return l / 2 + (l % 2) * 8;
      1: return (l * 2) % 16 + l / 8;
      2: return 15 - l;
      default: return l;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    bit ps0, pl0;
    if (rst) begin
      m_held = 0; m_age = 0; m_ps = 0; m_pl = 0;
      m_mode = 0; m_paused = 0; m_tick = 0; m_led = 1;
    end else begin
      ps0 = m_ps;
      pl0 = m_pl;
      m_ps = 0;
      m_pl = 0;
      if (key_flag && !key_value && !m_held) begin
        m_held = 1;
        m_age = 0;
      end else if (key_flag && key_value && m_held) begin
        m_held = 0;
        m_ps = (m_age < LONG_MAX);
      end else if (m_held) begin
        if (m_age == LONG_MAX - 1) m_pl = 1;
        m_age++;
      end
      if (ps0) begin
        m_mode = (m_mode + 1) % 4;
        m_led = entry_led(m_mode);
        m_tick = 0;
      end else if (!m_paused) begin
        if (m_tick == TICK_MAX - 1) begin
          m_tick = 0;
          m_led = step_led(m_mode, m_led);
        end else begin
          m_tick++;
        end
      end
      if (pl0) m_paused = !m_paused;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("led_out", {28'd0, led_out}, m_led);
    check("mode", {30'd0, mode}, m_mode);
    check("paused", {31'd0, paused}, {31'd0, m_paused});
    check("press_short", {31'd0, press_short}, {31'd0, m_ps});
    check("press_long", {31'd0, press_long}, {31'd0, m_pl});
  endtask

  // One clock with the given inputs; outputs are checked 1ns after the edge.
  task automatic cyc(input logic f, input logic v);
    key_flag  = f;
    key_value = v;
    @(posedge clk);
    #1;
    key_flag = 1'b0;
    check_model();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  int pulses;
  int guard;
  int hold;

  initial begin
    // 1: free-running SHR after reset
    do_reset(2);
    check("rst_led", {28'd0, led_out}, 32'h1);
    check("rst_mode", {30'd0, mode}, 32'h0);
    check("rst_paused", {31'd0, paused}, 32'h0);
    repeat (4) cyc(1'b0, 1'b1);
    check("t1_led4", {28'd0, led_out}, 32'h8);
    repeat (4) cyc(1'b0, 1'b1);
    check("t1_led8", {28'd0, led_out}, 32'h4);

    // 2: short press -> SHL
    cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    check("t2_short", {31'd0, press_short}, 32'h1);
    cyc(1'b0, 1'b1);
    check("t2_mode", {30'd0, mode}, 32'h1);
    check("t2_led", {28'd0, led_out}, 32'h1);
    repeat (4) cyc(1'b0, 1'b1);
    check("t2_led_step", {28'd0, led_out}, 32'h2);

    // 3: long press pauses, second long press resumes
    pulses = 0;
    cyc(1'b1, 1'b0);
    repeat (12) begin cyc(1'b0, 1'b0); pulses += press_long; end
    check("t3_long_pulses", pulses, 32'h1);
    check("t3_paused", {31'd0, paused}, 32'h1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    check("t3_no_short", {31'd0, press_short}, 32'h0);
    repeat (6) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (12) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    check("t3_resumed", {31'd0, paused}, 32'h0);
    repeat (8) cyc(1'b0, 1'b1);

    // 4: cycle through all modes
    do_reset(1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      check("t4_mode", {30'd0, mode}, i % 4);
      repeat (9) cyc(1'b0, 1'b1);
    end

    // 6: short pulse coincides with tick terminal count
    guard = 0;
    while (m_tick != 2 && guard < 20) begin cyc(1'b0, 1'b1); guard++; end
    check("t6_align_timeout", {31'd0, guard >= 20}, 32'h0);
    cyc(1'b1, 1'b0);
    guard = 0;
    while (m_tick != 2 && guard < 20) begin cyc(1'b0, 1'b0); guard++; end
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    check("t6_led_reload", {28'd0, led_out}, 32'h1);
    repeat (3) cyc(1'b0, 1'b1);
    check("t6_no_step_yet", {28'd0, led_out}, 32'h1);
    cyc(1'b0, 1'b1);
    check("t6_step", {28'd0, led_out}, 32'h2);

    // 5: redundant strobes and reset mid-press
    repeat (3) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    do_reset(2);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    check("t5_no_short", {31'd0, press_short}, 32'h0);
    check("t5_led", {28'd0, led_out}, 32'h1);
    check("t5_mode", {30'd0, mode}, 32'h0);

    // Randomized presses, holds and redundant strobes
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          hold = $urandom_range(1, 14);
          cyc(1'b1, 1'b0);
          repeat (hold) cyc(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0, 1'b0);
          cyc(1'b1, 1'b1);
        end
        2: cyc(1'b1, 1'b1);
        default: ;
      endcase
      repeat ($urandom_range(0, 9)) cyc(1'b0, 1'b1);
    end
    repeat (4) cyc(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
